// File: rtl/dm_responder.sv
// dm_responder: the data-memory slave for the pipeline's MEM-stage load/store port.
// It accepts one word read or write per handshake and answers with a one-cycle
// registered response a fixed LATENCY cycles after the accepting edge.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   req_valid/ready   request handshake (see below)
//   req_write         1 = store, 0 = load
//   req_addr          byte address
//   req_wdata         store data
//   resp_valid        one-cycle response strobe
//   resp_rdata        load data (0 for stores and errors; holds between responses)
//   resp_err          misaligned or out-of-range request
//   busy              a request has been accepted and not yet answered
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE and out of reset, so at most one request is in
// flight. The requester holds req_* stable until the transfer; req_valid while
// req_ready is low is ignored.
//
// Storage is a byte array in big-endian word order: byte a sits in bits 31:24.
module dm_responder #(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic [31:0] look_addr;
  logic        look_write;
  logic        look_err;
  logic [AW-1:0] look_idx;
  logic [31:0] look_word;
  logic        held_err;
  logic [AW-1:0] held_idx;
  logic        commit;

  assign req_ready = (state_q == IDLE) && rst_n;
  assign busy      = (state_q == WAIT) || (state_q == RESP);
  assign accept    = req_valid && req_ready;

  // The response is built on the edge that enters RESP. With LATENCY == 1 that
  // is the accepting edge itself, so the request is taken straight off the
  // port; otherwise it comes from the latched copy.
  assign look_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign look_write = (state_q == IDLE) ? req_write : write_q;
  assign look_err   = (look_addr[1:0] != 2'b00) || (look_addr > 32'(DEPTH_BYTES - 4));
  assign look_idx   = look_addr[AW-1:0];
  assign look_word  = {mem[look_idx], mem[look_idx + AW'(1)],
                       mem[look_idx + AW'(2)], mem[look_idx + AW'(3)]};

  // Stores commit on the edge that ends RESP; a reset on that edge drops them.
  assign held_err = (addr_q[1:0] != 2'b00) || (addr_q > 32'(DEPTH_BYTES - 4));
  assign held_idx = addr_q[AW-1:0];
  assign commit   = (state_q == RESP) && write_q && !held_err && rst_n;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = look_err;
            resp_rdata_d = (!look_write && !look_err) ? look_word : 32'h0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = look_err;
          resp_rdata_d = (!look_write && !look_err) ? look_word : 32'h0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Memory contents survive reset; only the commit is gated by it.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[held_idx]          <= wdata_q[31:24];
      mem[held_idx + AW'(1)] <= wdata_q[23:16];
      mem[held_idx + AW'(2)] <= wdata_q[15:8];
      mem[held_idx + AW'(3)] <= wdata_q[7:0];
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (LATENCY 2, 3 and 1) share clock and
// reset. A byte-array reference model predicts every response.
module tb_dm_responder;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err [3];
  logic        busy [3];

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0]));

  dm_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1]));

  dm_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
    .busy(busy[2]));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mm [3][DEPTH];

  typedef struct {
    int          inst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: error rule and big-endian byte layout from plain arithmetic.
  task automatic model_apply(input int i, input logic w, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] rd, output logic er);
    longint unsigned la;
    int b;
    la = a;
    er = (la % 4 != 0) || (la + 4 > DEPTH);
    rd = 32'h0;
    if (!er) begin
      b = int'(la);
      if (w) begin
        mm[i][b]   = d[31:24];
        mm[i][b+1] = d[23:16];
        mm[i][b+2] = d[15:8];
        mm[i][b+3] = d[7:0];
      end else begin
        rd = {mm[i][b], mm[i][b+1], mm[i][b+2], mm[i][b+3]};
      end
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
    int lat;
    bit acc;
    lat = lat_of(i);
    acc = 1'b0;
    rd = 32'h0;
    er = 1'b0;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      if (req_ready[i] === 1'b1) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[i] = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout inst%0d: got no req_ready expected ready within 20 cycles", i);
      return;
    end
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      chk1($sformatf("inst%0d_resp_valid_c%0d", i, c), resp_valid[i], c == lat);
      chk1($sformatf("inst%0d_busy_c%0d", i, c), busy[i], c <= lat);
      chk1($sformatf("inst%0d_req_ready_c%0d", i, c), req_ready[i], c > lat);
      if (c == lat) begin
        rd = resp_rdata[i];
        er = resp_err[i];
      end else begin
        chk1($sformatf("inst%0d_resp_err_quiet_c%0d", i, c), resp_err[i], 1'b0);
      end
      if (c > lat) chk32($sformatf("inst%0d_rdata_hold", i), resp_rdata[i], rd);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    int last_acc, acc_cnt;
    int pulse_cyc [$];
    logic [31:0] pulse_dat [$];
    logic [31:0] b2b_exp [4];

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
    end
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < DEPTH; b++) mm[i][b] = 8'h00;

    vecs[0]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
    vecs[1]  = '{0, 1'b1, 32'h0000_0008, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[2]  = '{0, 1'b0, 32'h0000_0008, 32'h0,         32'h1122_3344, 1'b0};
    vecs[3]  = '{0, 1'b0, 32'h0000_0006, 32'h0,         32'h0000_0000, 1'b1};
    vecs[4]  = '{0, 1'b0, 32'h0000_0080, 32'h0,         32'h0000_0000, 1'b1};
    vecs[5]  = '{0, 1'b1, 32'h0000_007E, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{0, 1'b0, 32'h0000_007C, 32'h0,         32'h0000_0000, 1'b0};
    vecs[7]  = '{0, 1'b1, 32'h0000_007C, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0};
    vecs[8]  = '{0, 1'b0, 32'h0000_007C, 32'h0,         32'hA5A5_5A5A, 1'b0};
    vecs[9]  = '{2, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    vecs[10] = '{2, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[11] = '{1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};

    // Reset and reset-state checks.
    @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk1($sformatf("inst%0d_ready_in_reset", i), req_ready[i], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("inst%0d_rst_resp_valid", i), resp_valid[i], 1'b0);
      chk1($sformatf("inst%0d_rst_resp_err", i), resp_err[i], 1'b0);
      chk32($sformatf("inst%0d_rst_resp_rdata", i), resp_rdata[i], 32'h0);
      chk1($sformatf("inst%0d_rst_busy", i), busy[i], 1'b0);
      chk1($sformatf("inst%0d_rst_ready", i), req_ready[i], 1'b1);
    end
    @(posedge clk); #1;

    // Zero every memory word through the port so the model starts in sync.
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < DEPTH; a += 4) do_req(i, 1'b1, 32'(a), 32'h0, rd, er);

    // Reset again: memory must survive it.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table.
    for (int j = 0; j < 12; j++) begin
      do_req(vecs[j].inst, vecs[j].wr, vecs[j].addr, vecs[j].wdata, rd, er);
      model_apply(vecs[j].inst, vecs[j].wr, vecs[j].addr, vecs[j].wdata, mrd, mer);
      chk32($sformatf("vec%0d_rdata", j), rd, vecs[j].exp_rd);
      chk1($sformatf("vec%0d_err", j), er, vecs[j].exp_err);
      if (j == 2) begin
        chk32("peek_byte_08", 32'(u_l2.mem[8]), 32'h11);
        chk32("peek_byte_0b", 32'(u_l2.mem[11]), 32'h44);
      end
      if (j == 5) begin
        chk32("peek_byte_7e", 32'(u_l2.mem[126]), 32'h00);
        chk32("peek_byte_7f", 32'(u_l2.mem[127]), 32'h00);
      end
    end

    // Back-to-back reads with req_valid held high, LATENCY 3.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] dv;
      dv = $urandom;
      do_req(1, 1'b1, 32'h20 + 32'(4 * k), dv, rd, er);
      model_apply(1, 1'b1, 32'h20 + 32'(4 * k), dv, mrd, mer);
      b2b_exp[k] = dv;
    end
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = 32'h20;
    last_acc = -100;
    acc_cnt  = 0;
    for (int n = 0; n < 24; n++) begin
      bit took;
      @(negedge clk);
      chk1($sformatf("b2b_busy_n%0d", n), busy[1], (n > last_acc) && (n <= last_acc + 3));
      if (resp_valid[1] === 1'b1) begin
        pulse_cyc.push_back(n);
        pulse_dat.push_back(resp_rdata[1]);
      end
      took = (req_valid[1] === 1'b1) && (req_ready[1] === 1'b1);
      if (took) last_acc = n;
      @(posedge clk); #1;
      if (took) begin
        acc_cnt++;
        if (acc_cnt < 4) req_addr[1] = 32'h20 + 32'(4 * acc_cnt);
        else req_valid[1] = 1'b0;
      end
    end
    chk32("b2b_pulse_count", 32'(pulse_cyc.size()), 32'd4);
    if (pulse_cyc.size() > 0) chk32("b2b_first_pulse", 32'(pulse_cyc[0]), 32'd3);
    for (int k = 0; k < 4 && k < pulse_cyc.size(); k++) begin
      chk32($sformatf("b2b_data%0d", k), pulse_dat[k], b2b_exp[k]);
      if (k > 0) chk32($sformatf("b2b_spacing%0d", k), 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'd4);
    end

    // Reset during WAIT discards a pending store.
    do_req(0, 1'b1, 32'h10, 32'h0102_0304, rd, er);
    model_apply(0, 1'b1, 32'h10, 32'h0102_0304, mrd, mer);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    chk1("abort_ready_before", req_ready[0], 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk1("abort_busy_wait", busy[0], 1'b1);
    chk1("abort_ready_in_reset", req_ready[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("abort_ready_after", req_ready[0], 1'b1);
    chk1("abort_busy_after", busy[0], 1'b0);
    for (int n = 0; n < 4; n++) begin
      chk1($sformatf("abort_no_resp%0d", n), resp_valid[0], 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er);
    chk32("abort_read_old", rd, 32'h0102_0304);
    chk1("abort_read_err", er, 1'b0);

    // Random traffic against the reference model.
    for (int r = 0; r < 60; r++) begin
      int i, sel;
      logic w;
      logic [31:0] a, d;
      i   = $urandom_range(0, 2);
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1)) | 32'h1;
      else if (sel == 8) a = 32'(DEPTH) + 32'($urandom_range(0, 63) * 4);
      else               a = $urandom;
      do_req(i, w, a, d, rd, er);
      model_apply(i, w, a, d, mrd, mer);
      chk32($sformatf("rand%0d_inst%0d_rdata_a%h", r, i, a), rd, mrd);
      chk1($sformatf("rand%0d_inst%0d_err_a%h", r, i, a), er, mer);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
